mdio_target: RTL and testbench

- IEEE 802.3 Clause 22 MDIO management responder (PHY side) for the Ethernet subsystem.
- Decodes frames driven by our MDIO master on mdc_pin/mdio_pin. Holds a small PHY-style register file, including KSZ-style indirect extended registers reached through regs 11/12. Returns live speed/duplex status.
- Used as a bench PHY model and as the management target for FPGA-hosted PHY emulation.

---
 rtl/mdio_target.sv | 388 ++++++++++++++++++++++++++++++++++++++
 tb/tb_mdio_target.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_target.sv
// -----------------------------------------------------------------------------
// mdio_target -- Clause 22 MDIO management responder (PHY side).
//
// Decodes MDIO frames from the management master, answers reads for its own
// PHY address and applies writes to a small PHY-style register file:
//   reg 0  control (soft reset in bit 15, AN restart in bit 9)
//   reg 9  1000BASE-T control
//   reg 11 indirect address (bit 15 = write enable, [8:0] = ext address)
//   reg 12 indirect data window onto ext regs 104h/105h/106h
//   reg 31 live speed/duplex status
//
// Optional feature macro: MDIO_TARGET_PREAMBLE_SUPPRESSION_EN
//   defined   : a start is accepted after a single preceding idle 1
//   undefined : 32 consecutive 1s are required before a start
//
// Ports
//   clock          system clock, at least 8x MDC
//   reset_n        asynchronous active-low reset
//   mdc_pin        MDC from the master (asynchronous, synchronised here)
//   mdio_pin       bidirectional MDIO, driven only in read turnaround/data
//   speed_in       link speed, reported in reg 31 [6:5]
//   duplex_in      duplex, reported in reg 31 [3]
//   ctrl_reg       current reg 0
//   gbit_ctrl_reg  current reg 9
//   ext_clk_skew   ext reg 104h
//   ext_rx_skew    ext reg 105h
//   ext_tx_skew    ext reg 106h
//   wr_strobe      one-clock pulse per committed write to this PHY address
//   wr_addr        REGAD of the last committed write
//   anerg_restart  one-clock pulse when reg 0 is written with bit 9 set
// -----------------------------------------------------------------------------
module mdio_target #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter logic [15:0] REG0_DEFAULT = 16'h1140,
    parameter logic [15:0] REG9_DEFAULT = 16'h0300
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mdc_pin,
    inout  wire         mdio_pin,
    input  logic [1:0]  speed_in,
    input  logic        duplex_in,
    output logic [15:0] ctrl_reg,
    output logic [15:0] gbit_ctrl_reg,
    output logic [15:0] ext_clk_skew,
    output logic [15:0] ext_rx_skew,
    output logic [15:0] ext_tx_skew,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic        anerg_restart
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA
    } state_t;

    // Number of consecutive idle 1s needed before a 0 is taken as a start bit.
`ifdef MDIO_TARGET_PREAMBLE_SUPPRESSION_EN
    localparam logic [5:0] PRE_MIN = 6'd1;
`else
    localparam logic [5:0] PRE_MIN = 6'd32;
`endif
    localparam logic [5:0] PRE_SAT  = 6'd32;
    localparam logic [8:0] EXT_BASE = 9'h104;
    localparam int         N_EXT    = 3;

    // Synchronisers. MDC resets high so that releasing reset while MDC is
    // high cannot fabricate a rising edge.
    logic mdc_s1_q,  mdc_s1_d;
    logic mdc_s2_q,  mdc_s2_d;
    logic mdc_s3_q,  mdc_s3_d;
    logic mdio_s1_q, mdio_s1_d;
    logic mdio_s2_q, mdio_s2_d;

    // Frame decoder state
    state_t      state_q,    state_d;
    logic [5:0]  pre_cnt_q,  pre_cnt_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic        op_hi_q,    op_hi_d;
    logic        is_read_q,  is_read_d;
    logic        match_q,    match_d;
    logic [4:0]  phy_sh_q,   phy_sh_d;
    logic [4:0]  regad_sh_q, regad_sh_d;
    logic [15:0] rd_sh_q,    rd_sh_d;
    logic [15:0] wr_sh_q,    wr_sh_d;
    logic        mdio_oe_q,  mdio_oe_d;
    logic        mdio_out_q, mdio_out_d;

    // Register file and strobes
    logic [15:0] ctrl_q,     ctrl_d;
    logic [15:0] gbit_q,     gbit_d;
    logic [15:0] ind_q,      ind_d;
    logic [15:0] ext_q [N_EXT];
    logic [15:0] ext_d [N_EXT];
    logic        wr_strobe_q, wr_strobe_d;
    logic [4:0]  wr_addr_q,   wr_addr_d;
    logic        anerg_q,     anerg_d;

    // Derived combinational signals
    logic        bit_evt;
    logic        mdio_bit;
    logic [4:0]  regad_now;
    logic [15:0] wdata_now;
    logic [N_EXT-1:0] ext_hit;
    logic [15:0] ext_rd;
    logic [15:0] rd_mux;

    assign mdio_pin = mdio_oe_q ? mdio_out_q : 1'bz;

    assign ctrl_reg      = ctrl_q;
    assign gbit_ctrl_reg = gbit_q;
    assign ext_clk_skew  = ext_q[0];
    assign ext_rx_skew   = ext_q[1];
    assign ext_tx_skew   = ext_q[2];
    assign wr_strobe     = wr_strobe_q;
    assign wr_addr       = wr_addr_q;
    assign anerg_restart = anerg_q;

    // A bit event is a rising edge of synchronised MDC; MDIO goes through the
    // same number of stages so the sampled bit lines up with that edge.
    assign bit_evt   = mdc_s2_q & ~mdc_s3_q;
    assign mdio_bit  = mdio_s2_q;
    assign regad_now = {regad_sh_q[3:0], mdio_bit};
    assign wdata_now = {wr_sh_q[14:0], mdio_bit};

    // One comparator per extended register against the indirect address.
    for (genvar gi = 0; gi < N_EXT; gi++) begin : g_ext_hit
        assign ext_hit[gi] = (ind_q[8:0] == EXT_BASE + 9'(gi));
    end

    always_comb begin
        ext_rd = '0;
        for (int i = 0; i < N_EXT; i++) begin
            if (ext_hit[i]) begin
                ext_rd = ext_q[i];
            end
        end
    end

    // Read map, indexed by the REGAD being completed on this bit.
    always_comb begin
        case (regad_now)
            5'd0:    rd_mux = ctrl_q;
            5'd9:    rd_mux = gbit_q;
            5'd11:   rd_mux = ind_q;
            5'd12:   rd_mux = ext_rd;
            5'd31:   rd_mux = {9'b0, speed_in, 1'b0, duplex_in, 3'b0};
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        mdc_s1_d  = mdc_pin;
        mdc_s2_d  = mdc_s1_q;
        mdc_s3_d  = mdc_s2_q;
        mdio_s1_d = mdio_pin;
        mdio_s2_d = mdio_s1_q;

        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        op_hi_d     = op_hi_q;
        is_read_d   = is_read_q;
        match_d     = match_q;
        phy_sh_d    = phy_sh_q;
        regad_sh_d  = regad_sh_q;
        rd_sh_d     = rd_sh_q;
        wr_sh_d     = wr_sh_q;
        mdio_oe_d   = mdio_oe_q;
        mdio_out_d  = mdio_out_q;
        ctrl_d      = ctrl_q;
        gbit_d      = gbit_q;
        ind_d       = ind_q;
        for (int i = 0; i < N_EXT; i++) begin
            ext_d[i] = ext_q[i];
        end
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        anerg_d     = 1'b0;

        if (bit_evt) begin
            case (state_q)
                ST_IDLE: begin
                    if (mdio_bit) begin
                        if (pre_cnt_q != PRE_SAT) begin
                            pre_cnt_d = pre_cnt_q + 6'd1;
                        end
                    end else begin
                        // The 0 is the first start bit when the preamble was
                        // long enough; either way it breaks the run of 1s.
                        if (pre_cnt_q >= PRE_MIN) begin
                            state_d = ST_START;
                        end
                        pre_cnt_d = '0;
                    end
                end

                ST_START: begin
                    if (mdio_bit) begin
                        state_d   = ST_OP;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = ST_IDLE;
                        pre_cnt_d = '0;
                    end
                end

                ST_OP: begin
                    if (bit_cnt_q == 4'd0) begin
                        op_hi_d   = mdio_bit;
                        bit_cnt_d = 4'd1;
                    end else if (op_hi_q != mdio_bit) begin
                        // 10 = read, 01 = write
                        is_read_d = op_hi_q;
                        state_d   = ST_PHYAD;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = ST_IDLE;
                        pre_cnt_d = '0;
                    end
                end

                ST_PHYAD: begin
                    phy_sh_d = {phy_sh_q[3:0], mdio_bit};
                    if (bit_cnt_q == 4'd4) begin
                        state_d   = ST_REGAD;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end

                ST_REGAD: begin
                    regad_sh_d = regad_now;
                    if (bit_cnt_q == 4'd4) begin
                        match_d   = (phy_sh_q == PHY_ADDR);
                        rd_sh_d   = rd_mux;
                        mdio_oe_d = 1'b0;
                        state_d   = ST_TA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end

                ST_TA: begin
                    // Outputs set on an event are seen by the master on the
                    // following edge: drive the TA 0 after TA bit 1, then
                    // data bit 15 after TA bit 2.
                    if (bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                        if (is_read_q && match_q) begin
                            mdio_oe_d  = 1'b1;
                            mdio_out_d = 1'b0;
                        end
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        if (is_read_q && match_q) begin
                            mdio_out_d = rd_sh_q[15];
                            rd_sh_d    = {rd_sh_q[14:0], 1'b0};
                        end
                    end
                end

                ST_DATA: begin
                    if (!is_read_q) begin
                        wr_sh_d = wdata_now;
                    end
                    if (bit_cnt_q == 4'd15) begin
                        mdio_oe_d = 1'b0;
                        state_d   = ST_IDLE;
                        pre_cnt_d = '0;
                        if (!is_read_q && match_q) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = regad_sh_q;
                            case (regad_sh_q)
                                5'd0: begin
                                    anerg_d = wdata_now[9];
                                    if (wdata_now[15]) begin
                                        ctrl_d = REG0_DEFAULT;
                                        gbit_d = REG9_DEFAULT;
                                        ind_d  = '0;
                                        for (int i = 0; i < N_EXT; i++) begin
                                            ext_d[i] = '0;
                                        end
                                    end else begin
                                        // AN restart is self-clearing.
                                        ctrl_d = wdata_now & 16'hFDFF;
                                    end
                                end
                                5'd9:  gbit_d = wdata_now;
                                5'd11: ind_d  = wdata_now;
                                5'd12: begin
                                    if (ind_q[15]) begin
                                        for (int i = 0; i < N_EXT; i++) begin
                                            if (ext_hit[i]) begin
                                                ext_d[i] = wdata_now;
                                            end
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (is_read_q && match_q) begin
                            mdio_out_d = rd_sh_q[15];
                            rd_sh_d    = {rd_sh_q[14:0], 1'b0};
                        end
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    pre_cnt_d = '0;
                    mdio_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mdc_s1_q    <= 1'b1;
            mdc_s2_q    <= 1'b1;
            mdc_s3_q    <= 1'b1;
            mdio_s1_q   <= 1'b1;
            mdio_s2_q   <= 1'b1;
            state_q     <= ST_IDLE;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            op_hi_q     <= 1'b0;
            is_read_q   <= 1'b0;
            match_q     <= 1'b0;
            phy_sh_q    <= '0;
            regad_sh_q  <= '0;
            rd_sh_q     <= '0;
            wr_sh_q     <= '0;
            mdio_oe_q   <= 1'b0;
            mdio_out_q  <= 1'b0;
            ctrl_q      <= REG0_DEFAULT;
            gbit_q      <= REG9_DEFAULT;
            ind_q       <= '0;
            for (int i = 0; i < N_EXT; i++) begin
                ext_q[i] <= '0;
            end
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            anerg_q     <= 1'b0;
        end else begin
            mdc_s1_q    <= mdc_s1_d;
            mdc_s2_q    <= mdc_s2_d;
            mdc_s3_q    <= mdc_s3_d;
            mdio_s1_q   <= mdio_s1_d;
            mdio_s2_q   <= mdio_s2_d;
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            op_hi_q     <= op_hi_d;
            is_read_q   <= is_read_d;
            match_q     <= match_d;
            phy_sh_q    <= phy_sh_d;
            regad_sh_q  <= regad_sh_d;
            rd_sh_q     <= rd_sh_d;
            wr_sh_q     <= wr_sh_d;
            mdio_oe_q   <= mdio_oe_d;
            mdio_out_q  <= mdio_out_d;
            ctrl_q      <= ctrl_d;
            gbit_q      <= gbit_d;
            ind_q       <= ind_d;
            for (int i = 0; i < N_EXT; i++) begin
                ext_q[i] <= ext_d[i];
            end
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            anerg_q     <= anerg_d;
        end
    end

endmodule

// File: tb/tb_mdio_target.sv
// -----------------------------------------------------------------------------
// tb_mdio_target -- directed plus randomized MDIO frames against mdio_target,
// checked against a register-level model of the PHY kept in this bench.
// MDIO has a pull-up here, so a released line reads back as 1.
// -----------------------------------------------------------------------------
module tb_mdio_target;

    localparam logic [4:0]  PHY_ADDR     = 5'd0;
    localparam logic [15:0] REG0_DEFAULT = 16'h1140;
    localparam logic [15:0] REG9_DEFAULT = 16'h0300;
    localparam logic [17:0] ALL_RELEASED = 18'h3FFFF;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        mdc       = 1'b1;
    logic        tb_en     = 1'b0;
    logic        tb_val    = 1'b1;
    logic [1:0]  speed_in  = 2'b00;
    logic        duplex_in = 1'b0;
    wire         mdio_pin;
    logic [15:0] ctrl_reg, gbit_ctrl_reg, ext_clk_skew, ext_rx_skew, ext_tx_skew;
    logic        wr_strobe, anerg_restart;
    logic [4:0]  wr_addr;

    assign mdio_pin = tb_en ? tb_val : 1'bz;
    pullup (mdio_pin);

    always #5 clk = ~clk;

    mdio_target #(
        .PHY_ADDR     (PHY_ADDR),
        .REG0_DEFAULT (REG0_DEFAULT),
        .REG9_DEFAULT (REG9_DEFAULT)
    ) dut (
        .clock         (clk),
        .reset_n       (reset_n),
        .mdc_pin       (mdc),
        .mdio_pin      (mdio_pin),
        .speed_in      (speed_in),
        .duplex_in     (duplex_in),
        .ctrl_reg      (ctrl_reg),
        .gbit_ctrl_reg (gbit_ctrl_reg),
        .ext_clk_skew  (ext_clk_skew),
        .ext_rx_skew   (ext_rx_skew),
        .ext_tx_skew   (ext_tx_skew),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .anerg_restart (anerg_restart)
    );

    int n_assert    = 0;
    int n_fail      = 0;
    int strobe_seen = 0;
    int anerg_seen  = 0;

    // Count high cycles, so a pulse longer than one clock shows up as extra.
    always @(negedge clk) begin
        if (wr_strobe)     strobe_seen <= strobe_seen + 1;
        if (anerg_restart) anerg_seen  <= anerg_seen + 1;
    end

    // ---------------- reference model ----------------
    logic [15:0] m_ctrl, m_gbit, m_ind;
    logic [15:0] m_ext [3];
    logic [4:0]  m_wr_addr;
    int          exp_strobe = 0;
    int          exp_anerg  = 0;

    task automatic m_defaults();
        m_ctrl = REG0_DEFAULT;
        m_gbit = REG9_DEFAULT;
        m_ind  = 16'h0000;
        for (int i = 0; i < 3; i++) m_ext[i] = 16'h0000;
    endtask

    function automatic logic [15:0] m_read(input logic [4:0] r);
        int a;
        a = int'(m_ind[8:0]);
        case (r)
            5'd0:  return m_ctrl;
            5'd9:  return m_gbit;
            5'd11: return m_ind;
            5'd12: return (a >= 'h104 && a <= 'h106) ? m_ext[a - 'h104] : 16'h0000;
            5'd31: return 16'(int'(speed_in) * 32 + int'(duplex_in) * 8);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_write(input logic [4:0] r, input logic [15:0] d);
        int a;
        a = int'(m_ind[8:0]);
        exp_strobe++;
        m_wr_addr = r;
        case (r)
            5'd0: begin
                if (d[9]) exp_anerg++;
                if (d[15]) m_defaults();
                else       m_ctrl = d & ~16'h0200;
            end
            5'd9:  m_gbit = d;
            5'd11: m_ind  = d;
            5'd12: if (m_ind[15] && a >= 'h104 && a <= 'h106) m_ext[a - 'h104] = d;
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " ctrl_reg"},      32'(ctrl_reg),      32'(m_ctrl));
        check({tag, " gbit_ctrl_reg"}, 32'(gbit_ctrl_reg), 32'(m_gbit));
        check({tag, " ext_clk_skew"},  32'(ext_clk_skew),  32'(m_ext[0]));
        check({tag, " ext_rx_skew"},   32'(ext_rx_skew),   32'(m_ext[1]));
        check({tag, " ext_tx_skew"},   32'(ext_tx_skew),   32'(m_ext[2]));
        check({tag, " wr_strobe cycles"}, 32'(strobe_seen), 32'(exp_strobe));
        check({tag, " anerg cycles"},  32'(anerg_seen),    32'(exp_anerg));
        check({tag, " wr_addr"},       32'(wr_addr),       32'(m_wr_addr));
    endtask

    // ---------------- master ----------------
    // One MDC period: drive (or release) MDIO with MDC low, sample just
    // before MDC rises, optionally pulse reset_n while MDC is low.
    task automatic mdc_cycle(input logic en, input logic val, input logic rst_pulse,
                             output logic s);
        mdc    = 1'b0;
        tb_en  = en;
        tb_val = val;
        if (rst_pulse) begin
            @(negedge clk);
            reset_n = 1'b0;
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        s   = mdio_pin;
        mdc = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // rd returns the 18 line samples of TA + data (bit 17 = TA bit 1).
    // reset_at selects a TA/data slot (17..0) to pulse reset in; -1 for none.
    task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] regad, input logic [15:0] wdata,
                         input int reset_at, output logic [17:0] rd);
        logic        s;
        logic [13:0] hdr;
        logic [17:0] tail;
        hdr  = {2'b01, op, phy, regad};
        tail = {2'b10, wdata};
        for (int i = 0; i < pre_len; i++) mdc_cycle(1'b1, 1'b1, 1'b0, s);
        for (int i = 13; i >= 0; i--)     mdc_cycle(1'b1, hdr[i], 1'b0, s);
        for (int i = 17; i >= 0; i--) begin
            if (op == 2'b10) mdc_cycle(1'b0, 1'b0, (i == reset_at), s);
            else             mdc_cycle(1'b1, tail[i], (i == reset_at), s);
            rd[i] = s;
        end
        tb_en = 1'b0;
        mdc_cycle(1'b0, 1'b1, 1'b0, s);   // trailing idle bit, line released
    endtask

    task automatic do_write(input logic [4:0] phy, input logic [4:0] r, input logic [15:0] d);
        logic [17:0] rd;
        frame(32, 2'b01, phy, r, d, -1, rd);
        if (phy == PHY_ADDR) m_write(r, d);
        $display("write phy=%0d reg=%0d data=%h", phy, r, d);
    endtask

    task automatic do_read(input logic [4:0] phy, input logic [4:0] r, input string tag);
        logic [17:0] rd, exp;
        exp = (phy == PHY_ADDR) ? {2'b10, m_read(r)} : ALL_RELEASED;
        frame(32, 2'b10, phy, r, 16'h0000, -1, rd);
        $display("read  phy=%0d reg=%0d line=%h", phy, r, rd);
        check({tag, " read TA+data"}, 32'(rd), 32'(exp));
        check({tag, " released after"}, 32'(mdio_pin), 32'(1'b1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] rd;
        logic [4:0]  r, phy;
        logic [15:0] d;
        logic [4:0]  reg_pick [6];
        reg_pick[0] = 5'd0;  reg_pick[1] = 5'd9;  reg_pick[2] = 5'd11;
        reg_pick[3] = 5'd12; reg_pick[4] = 5'd31; reg_pick[5] = 5'd3;

        m_defaults();
        m_wr_addr = 5'd0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_state("reset");
        check("reset mdio released", 32'(mdio_pin), 32'(1'b1));

        // Basic write to reg 9
        do_write(PHY_ADDR, 5'd9, 16'h0200);
        check_state("write reg9");
        check("reg9 literal", 32'(gbit_ctrl_reg), 32'h0200);

        // Indirect ext reg access
        do_write(PHY_ADDR, 5'd11, 16'h8104);
        do_write(PHY_ADDR, 5'd12, 16'h6282);
        check_state("ext write");
        check("ext_clk literal", 32'(ext_clk_skew), 32'h6282);
        do_write(PHY_ADDR, 5'd11, 16'h0104);
        do_read(PHY_ADDR, 5'd12, "ext read");
        do_write(PHY_ADDR, 5'd12, 16'hBEEF);   // write mode off: discarded
        check_state("ext discard");

        // Status register
        speed_in  = 2'b10;
        duplex_in = 1'b1;
        do_read(PHY_ADDR, 5'd31, "status");

        // Soft reset with AN restart
        do_write(PHY_ADDR, 5'd0, 16'h9340);
        check_state("soft reset");
        check("ctrl default", 32'(ctrl_reg), 32'(REG0_DEFAULT));
        do_write(PHY_ADDR, 5'd0, 16'h0340);
        check_state("ctrl AN clear");

        // Foreign PHY address
        do_read(5'd5, 5'd31, "foreign read");
        do_write(5'd5, 5'd9, 16'h1234);
        check_state("foreign write");

        // Invalid opcode, then a normal frame
        frame(32, 2'b11, PHY_ADDR, 5'd9, 16'h0000, -1, rd);
        $display("bad-op frame");
        check_state("bad op");
        do_read(PHY_ADDR, 5'd9, "after bad op");

        // Short preamble
        frame(16, 2'b01, PHY_ADDR, 5'd9, 16'h0000, -1, rd);
`ifdef MDIO_TARGET_PREAMBLE_SUPPRESSION_EN
        m_write(5'd9, 16'h0000);
`endif
        $display("short-preamble write reg=9 data=0000");
        check_state("short preamble");

        // Reset during data: nothing committed, everything at reset values
        do_write(PHY_ADDR, 5'd9, 16'h0055);
        frame(32, 2'b01, PHY_ADDR, 5'd9, 16'h0000, 10, rd);
        m_defaults();
        m_wr_addr = 5'd0;
        $display("write reg=9 aborted by reset");
        check_state("reset mid data");
        do_read(PHY_ADDR, 5'd9, "after reset");

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            speed_in  = 2'($urandom_range(0, 3));
            duplex_in = 1'($urandom_range(0, 1));
            phy = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : PHY_ADDR;
            r   = reg_pick[$urandom_range(0, 5)];
            d   = 16'($urandom);
            if (r == 5'd11) d = {1'($urandom_range(0, 1)), 6'd0, 9'h104 + 9'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) do_read(phy, r, "random");
            else                           do_write(phy, r, d);
            check_state("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
